seg_scan_4digit: RTL and testbench

Four-digit time-multiplexed seven-segment driver that sits directly downstream of the single-digit BCD decode stage and replaces its fixed anode output. It latches a 16-bit packed value (four 4-bit digits) on a load strobe, scans the four anodes in turn at a programmable refresh rate, and drives the shared active-low cathodes with the decoded digit. Digit codes 10–15 show `code−10` and raise the range flag `z`, keeping the single-digit stage's convention.

---
 rtl/seg_scan_4digit.sv | 124 ++++++++++++
 tb/tb_seg_scan_4digit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/seg_scan_4digit.sv
// Four-digit multiplexed seven-segment driver with latched display value and programmable dwell.
// Optional leading-zero blanking is enabled by defining SEG_BLANK_LZ_EN.
module seg_scan_4digit #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] v,
  output logic        ack,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        z
);

  typedef enum logic [1:0] {
    D0 = 2'd0,
    D1 = 2'd1,
    D2 = 2'd2,
    D3 = 2'd3
  } scan_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [15:0]      disp_r;
  logic [CNT_W-1:0] cnt_r;
  scan_t            idx_r;

  scan_t            idx_nxt_s;
  logic [3:0]       digit_s;
  logic             blank_s;
  logic [6:0]       seg_nxt_s;
  logic [3:0]       an_nxt_s;
  logic             z_nxt_s;

  // Codes 10-15 wrap to 0-5 so out-of-range digits still show something readable.
  function automatic logic [6:0] decode7(input logic [3:0] code);
    logic [6:0] pat;
    case (code)
      4'd0, 4'd10: pat = 7'b0000001;
      4'd1, 4'd11: pat = 7'b1001111;
      4'd2, 4'd12: pat = 7'b0010010;
      4'd3, 4'd13: pat = 7'b0000110;
      4'd4, 4'd14: pat = 7'b1001100;
      4'd5, 4'd15: pat = 7'b0100100;
      4'd6:        pat = 7'b0100000;
      4'd7:        pat = 7'b0001111;
      4'd8:        pat = 7'b0000000;
      4'd9:        pat = 7'b0000100;
      default:     pat = 7'b1111111;
    endcase
    return pat;
  endfunction

  function automatic logic over9(input logic [3:0] d);
    return (d > 4'd9);
  endfunction

  // Next-state and next-output logic for the scan.
  always_comb begin
    idx_nxt_s = D0;
    case (idx_r)
      D0:      idx_nxt_s = D1;
      D1:      idx_nxt_s = D2;
      D2:      idx_nxt_s = D3;
      D3:      idx_nxt_s = D0;
      default: idx_nxt_s = D0;
    endcase

    digit_s = disp_r[{idx_r, 2'b00} +: 4];
    an_nxt_s = ~(4'b0001 << idx_r);

    blank_s = 1'b0;
`ifdef SEG_BLANK_LZ_EN
    // A digit goes dark only when it and every digit to its left are zero.
    case (idx_r)
      D3:      blank_s = (disp_r[15:12] == 4'd0);
      D2:      blank_s = (disp_r[15:8] == 8'd0);
      D1:      blank_s = (disp_r[15:4] == 12'd0);
      default: blank_s = 1'b0;
    endcase
`else
    blank_s = 1'b0;
`endif

    if (blank_s) begin
      seg_nxt_s = 7'b1111111;
    end else begin
      seg_nxt_s = decode7(digit_s);
    end

    z_nxt_s = over9(disp_r[15:12]) | over9(disp_r[11:8]) |
              over9(disp_r[7:4])   | over9(disp_r[3:0]);
  end

  // Display register, refresh counter, scan state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_r <= 16'h0000;
      cnt_r  <= '0;
      idx_r  <= D0;
      ack    <= 1'b0;
      an     <= 4'b1110;
      seg    <= 7'b0000001;
      z      <= 1'b0;
    end else begin
      ack <= load;
      if (load) begin
        disp_r <= v;
      end
      if (cnt_r == CNT_LAST) begin
        cnt_r <= '0;
        idx_r <= idx_nxt_s;
      end else begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      an  <= an_nxt_s;
      seg <= seg_nxt_s;
      z   <= z_nxt_s;
    end
  end

endmodule

// File: tb/tb_seg_scan_4digit.sv
// Scoreboard bench for seg_scan_4digit at REFRESH_DIV=4; expected outputs are queued
// at drive time from a cycle-count reference and popped once the edge has happened.
module tb_seg_scan_4digit;

  logic        clk;
  logic        reset;
  logic        load;
  logic [15:0] v;
  logic        ack;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        z;

  seg_scan_4digit #(.REFRESH_DIV(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .load(load), .v(v),
    .ack(ack), .an(an), .seg(seg), .z(z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       z;
    logic       ack;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference state: last accepted value and number of edges since the reset edge.
  logic [15:0] m_disp;
  int          m_n;

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    case (d % 4'd10)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return 7'bxxxxxxx;
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, want, m_n);
    end
  endtask

  task automatic step(input logic rst, input logic ld, input logic [15:0] val);
    exp_t e;
    int   pos;
    logic blank;
    logic [3:0] d;
    @(negedge clk);
    reset = rst;
    load  = ld;
    v     = val;
    if (rst) begin
      e = '{an: 4'b1110, seg: 7'b0000001, z: 1'b0, ack: 1'b0};
      m_disp = 16'h0000;
      m_n    = 0;
    end else begin
      pos = (m_n / 4) % 4;
      d   = m_disp[pos*4 +: 4];
      blank = 1'b0;
`ifdef SEG_BLANK_LZ_EN
      if (pos > 0 && (m_disp >> (pos*4)) == 16'h0000) blank = 1'b1;
`endif
      e.an  = 4'b1111 & ~(4'b0001 << pos);
      e.seg = blank ? 7'b1111111 : ref_seg(d);
      e.z   = (m_disp[3:0] > 4'd9) || (m_disp[7:4] > 4'd9) ||
              (m_disp[11:8] > 4'd9) || (m_disp[15:12] > 4'd9);
      e.ack = ld;
      if (ld) m_disp = val;
      m_n++;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("an",  {12'd0, an},  {12'd0, e.an});
    check("seg", {9'd0, seg},  {9'd0, e.seg});
    check("z",   {15'd0, z},   {15'd0, e.z});
    check("ack", {15'd0, ack}, {15'd0, e.ack});
    check("one_anode_low", 16'($countones(an)), 16'd3);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000);
  endtask

  initial begin
    reset = 1'b1;
    load  = 1'b0;
    v     = 16'h0000;
    m_disp = 16'h0000;
    m_n    = 0;

    // Reset and idle scan over a full frame.
    step(1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 16'h0000);
    idle(17);

    // Digits below ten.
    step(1'b0, 1'b1, 16'h1234);
    idle(18);

    // Out-of-range digits, then clear them.
    step(1'b0, 1'b1, 16'hFA09);
    idle(18);
    step(1'b0, 1'b1, 16'h0009);
    idle(6);

    // Reset in the middle of D2 with a load on the same edge.
    step(1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 16'h8421);
    idle(8);
    step(1'b1, 1'b1, 16'h9999);
    idle(10);

    // Load exactly on an index advance edge.
    while (m_n % 4 != 3) idle(1);
    step(1'b0, 1'b1, 16'h5678);
    idle(8);
    while (m_n % 4 != 3) idle(1);
    step(1'b0, 1'b1, 16'hC3B7);
    idle(6);

    // Leading-zero patterns.
    step(1'b0, 1'b1, 16'h0050);
    idle(17);
    step(1'b0, 1'b1, 16'h0000);
    idle(17);

    // Back-to-back loads; the last one must win.
    step(1'b0, 1'b1, 16'h1111);
    step(1'b0, 1'b1, 16'h2222);
    step(1'b0, 1'b1, 16'h0987);
    idle(17);

    // Random loads scattered over several frames.
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 5) == 0) step(1'b0, 1'b1, 16'($urandom));
      else idle(1);
    end

    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
